// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the frame-buffer blocks (rectangle fill
// engine, frame memory, scan-out reader).
//   - default frame geometry and bus widths
//   - fill-engine FSM state encoding
//   - pixel colour type
//   - clip_end(): clipped exclusive end coordinate of a span
package fb_pkg;

    localparam int FB_W_DEF    = 160;
    localparam int FB_H_DEF    = 120;
    localparam int ADDR_W_DEF  = 16;
    localparam int COLOR_W_DEF = 3;
    localparam int X_W_DEF     = 8;
    localparam int Y_W_DEF     = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [COLOR_W_DEF-1:0] color_t;

    // Exclusive end of [start, start+len) clipped to limit. The 16-bit sum
    // is wide enough for any 8-bit start plus 8-bit length, so it never wraps.
    function automatic logic [15:0] clip_end(input logic [15:0] start,
                                             input logic [15:0] len,
                                             input logic [15:0] limit);
        logic [15:0] sum;
        sum = start + len;
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: rectangle fill engine driving the frame-buffer write port.
// Accepts one command (x, y, w, h, colour) per valid/ready handshake, clips
// it to the frame and emits one pixel write per cycle in row-major order,
// addr = y*FB_W + x.
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, and the source must hold the command
// stable until it is taken.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake
//   cmd_x, cmd_y        top-left corner
//   cmd_w, cmd_h        size in pixels
//   cmd_color           fill colour
//   cmd_clear           (only with FB_RECT_CLEAR_EN) fill the whole frame
//   mem_wr, mem_addr,   frame memory write port; addr/data hold their last
//   mem_di              value while mem_wr is low
//   busy                high from accept until the command has finished
//   done                one-cycle pulse when a command completes
//   dbg_state           current FSM state, for observation only
//
// Optional feature macro: FB_RECT_CLEAR_EN adds cmd_clear. When set at the
// handshake the geometry is ignored and addresses 0..FB_W*FB_H-1 are written
// with a plain linear count.
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter int FB_W    = FB_W_DEF,
    parameter int FB_H    = FB_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [X_W-1:0]     cmd_w,
    input  logic [Y_W-1:0]     cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
`ifdef FB_RECT_CLEAR_EN
    input  logic               cmd_clear,
`endif
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_di,
    output logic               busy,
    output logic               done,
    output state_t             dbg_state
);

    localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

    state_t             r_state,    w_state;
    logic [X_W-1:0]     r_col,      w_col;
    logic [X_W-1:0]     r_x0,       w_x0;
    logic [X_W-1:0]     r_x_last,   w_x_last;
    logic [Y_W-1:0]     r_row,      w_row;
    logic [Y_W-1:0]     r_y_last,   w_y_last;
    logic [ADDR_W-1:0]  r_row_base, w_row_base;
    logic [ADDR_W-1:0]  r_addr,     w_addr;
    logic [COLOR_W-1:0] r_di,       w_di;
    logic               r_wr,       w_wr;
    logic               r_busy,     w_busy;
    logic               r_done,     w_done;
    logic               r_clear,    w_clear;

    logic               w_cmd_clear;
    logic               w_empty;
    logic [ADDR_W-1:0]  w_y_base;

`ifdef FB_RECT_CLEAR_EN
    assign w_cmd_clear = cmd_clear;
`else
    assign w_cmd_clear = 1'b0;
`endif

    assign w_empty = (cmd_w == '0) || (cmd_h == '0) ||
                     (16'(cmd_x) >= 16'(FB_W)) || (16'(cmd_y) >= 16'(FB_H));

    // Constant-coefficient product, used only once per command to seed the
    // row base; row advances afterwards are pure additions of FB_W.
    assign w_y_base = ADDR_W'(cmd_y) * FB_W_A;

    always_comb begin
        w_state    = r_state;
        w_col      = r_col;
        w_x0       = r_x0;
        w_x_last   = r_x_last;
        w_row      = r_row;
        w_y_last   = r_y_last;
        w_row_base = r_row_base;
        w_addr     = r_addr;
        w_di       = r_di;
        w_wr       = 1'b0;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_clear    = r_clear;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_busy  = 1'b1;
                    w_clear = w_cmd_clear;
                    if (w_cmd_clear) begin
                        w_state = ST_FILL;
                        w_wr    = 1'b1;
                        w_addr  = '0;
                        w_di    = cmd_color;
                    end else if (w_empty) begin
                        w_state = ST_DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_state    = ST_FILL;
                        w_wr       = 1'b1;
                        w_di       = cmd_color;
                        w_col      = cmd_x;
                        w_x0       = cmd_x;
                        w_row      = cmd_y;
                        w_row_base = w_y_base;
                        w_addr     = w_y_base + ADDR_W'(cmd_x);
                        // Store inclusive last coordinates so the scan
                        // compares against registers of the field width.
                        w_x_last   = X_W'(clip_end(16'(cmd_x), 16'(cmd_w),
                                                   16'(FB_W)) - 16'd1);
                        w_y_last   = Y_W'(clip_end(16'(cmd_y), 16'(cmd_h),
                                                   16'(FB_H)) - 16'd1);
                    end
                end
            end

            ST_FILL: begin
                // The registered outputs currently carry pixel (r_col, r_row);
                // decide what the next cycle carries.
                w_wr = 1'b1;
                if (r_clear) begin
                    if (r_addr == LAST_ADDR) begin
                        w_wr    = 1'b0;
                        w_done  = 1'b1;
                        w_state = ST_DONE;
                    end else begin
                        w_addr = r_addr + 1'b1;
                    end
                end else if (r_col == r_x_last) begin
                    if (r_row == r_y_last) begin
                        w_wr    = 1'b0;
                        w_done  = 1'b1;
                        w_state = ST_DONE;
                    end else begin
                        w_row      = r_row + 1'b1;
                        w_col      = r_x0;
                        w_row_base = r_row_base + FB_W_A;
                        w_addr     = r_row_base + FB_W_A + ADDR_W'(r_x0);
                    end
                end else begin
                    w_col  = r_col + 1'b1;
                    w_addr = r_addr + 1'b1;
                end
            end

            ST_DONE: begin
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_x0       <= '0;
            r_x_last   <= '0;
            r_row      <= '0;
            r_y_last   <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_di       <= '0;
            r_wr       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_clear    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_col      <= w_col;
            r_x0       <= w_x0;
            r_x_last   <= w_x_last;
            r_row      <= w_row;
            r_y_last   <= w_y_last;
            r_row_base <= w_row_base;
            r_addr     <= w_addr;
            r_di       <= w_di;
            r_wr       <= w_wr;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_clear    <= w_clear;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign mem_wr    = r_wr;
    assign mem_addr  = r_addr;
    assign mem_di    = r_di;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: doc/fb_rect_fill.md
Name: fb_rect_fill

Overview:
Rectangle-fill engine feeding the frame-buffer memory write port (clk, wr, addr, di); it sits directly upstream of that memory.
- Accepts one rectangle command per valid/ready handshake: x, y, width, height, colour.
- Clips the rectangle to the frame and issues one pixel write per cycle, row-major, addr = y*FB_W + x.
- Game logic uses it to draw bottle, table and background blocks without per-pixel sequencing.

Parameters:
FB_W, 160, frame width in pixels
FB_H, 120, frame height in pixels
ADDR_W, 16, memory address width; must satisfy FB_W*FB_H <= 2**ADDR_W
COLOR_W, 3, pixel colour width (RGB bit per channel)
X_W, 8, width of x/width command fields
Y_W, 7, width of y/height command fields

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command (high only in IDLE)
cmd_x  input  X_W  left column
cmd_y  input  Y_W  top row
cmd_w  input  X_W  width in pixels
cmd_h  input  Y_W  height in pixels
cmd_color  input  COLOR_W  fill colour
mem_wr  output  1  write strobe to frame memory
mem_addr  output  ADDR_W  write address
mem_di  output  COLOR_W  write data
busy  output  1  high from accept until done
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, rst=1): state IDLE; mem_wr=0, mem_addr=0, mem_di=0, busy=0, done=0, cmd_ready=1 after release. Reset mid-fill aborts immediately; remaining pixels are not written.
- FSM states: IDLE, FILL, DONE.
- IDLE: cmd_ready=1. Handshake (cmd_valid && cmd_ready at edge N) latches all fields.
  - Clip: x_end = min(x+w, FB_W); y_end = min(y+h, FB_H), using (X_W+1)/(Y_W+1)-bit sums so there is no wrap.
  - Empty if w==0, h==0, x>=FB_W or y>=FB_H. Empty -> DONE, no writes.
  - Otherwise -> FILL; busy=1 from edge N.
- FILL: all outputs registered.
  - First write appears at cycle N+1: mem_wr=1, mem_addr = y*FB_W + x, mem_di = colour.
  - Each cycle column +1 and addr +1.
  - At column x_end-1: row +1; addr = row_base + FB_W + x, where row_base is an incremental register. No multiplier.
  - After the write at (x_end-1, y_end-1) -> DONE.
  - Exactly (x_end-x)*(y_end-y) consecutive write cycles, no bubbles. cmd_ready=0 throughout.
- DONE: mem_wr=0, done=1 for one cycle, busy=0 on the following edge; -> IDLE.
- mem_addr and mem_di hold their last values when mem_wr=0.
- cmd_valid while busy is ignored; the command must be held until cmd_ready.

Optional Feature:
FB_RECT_CLEAR_EN
- Defined: adds input port cmd_clear (1 bit), sampled at handshake. When 1, x/y/w/h are ignored and the whole frame is filled: addr 0..FB_W*FB_H-1 with cmd_color, a linear count with no row logic, FB_W*FB_H write cycles.
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Shared package fb_pkg holds FB_W, FB_H, ADDR_W and COLOR_W defaults, plus the FSM state enum (IDLE, FILL, DONE) and the pixel colour typedef. The memory block and the scan-out reader also use these.
- No sub-module is needed. The clip computation may be a function in fb_pkg.

Test Plan:
- Single pixel: x=3, y=1, w=1, h=1, colour 1 -> one mem_wr cycle, addr 163, di 1; done one cycle later; memory at 163 reads 1.
- 2x2 block: x=3, y=1, colour 2 -> writes to 163, 164, 323, 324 in that order on four consecutive cycles; busy high throughout.
- Clip at corner: x=159, y=119, w=5, h=5, colour 7 -> exactly one write, addr 19199.
- Empty commands: w=0, then x=200 -> zero mem_wr cycles; done pulse one cycle after accept; cmd_ready returns high.
- Backpressure/reset: cmd_valid held during a 10x10 fill -> second command accepted only after done. Assert rst at write 37 -> mem_wr=0 immediately, no further writes, cmd_ready=1 after release.
- FB_RECT_CLEAR_EN: cmd_clear=1, colour 4 -> 19200 writes, addr 0..19199, all di=4, then done.
